// File: rtl/updown_ctr_pkg.sv
// Shared constants for the up/down modulus counter and its helpers.
package updown_ctr_pkg;

    // Behaviour at the ends of the count range
    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    // Direction encoding, matches the raw board switch polarity
    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/sw_debounce.sv
// Switch conditioner: 2-flop synchroniser followed by a stable-count debouncer.
// The output only moves after DEB_CYCLES consecutive synchronised samples that
// disagree with it; any agreeing sample restarts the count.
module sw_debounce #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw_in,
    output logic sw_out
);

    // Counter only needs to reach DEB_CYCLES-1; the final agreeing sample commits.
    localparam int CW = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    if (DEB_CYCLES < 1) begin : g_bad_deb
        $error("sw_debounce: DEB_CYCLES must be >= 1");
    end

    logic          r_sync1;
    logic          r_sync2;
    logic [CW-1:0] r_cnt;
    logic          r_out;

    // Bring the asynchronous switch into the clk domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= sw_in;
            r_sync2 <= r_sync1;
        end
    end

    // Accept a new level only after it has been stable long enough
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_out <= 1'b0;
        end else if (r_sync2 == r_out) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_LAST) begin
            r_cnt <= '0;
            r_out <= r_sync2;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign sw_out = r_out;

endmodule

// File: rtl/updown_mod_counter.sv
// Up/down counter over 0..MOD_MAX with wrap or saturate at the ends,
// synchronous load, enable, debounced direction switch and a terminal-count pulse.
module updown_mod_counter
    import updown_ctr_pkg::*;
#(
    parameter int WIDTH      = 3,
    parameter int MOD_MAX    = 7,
    parameter int SAT_MODE   = 0,
    parameter int DEB_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             dir_sw,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             dir,
    output logic             tc,
    output logic             at_max,
    output logic             at_min
);

    localparam logic [WIDTH-1:0] C_MAX = WIDTH'(MOD_MAX);
    localparam bit               C_SAT = (SAT_MODE == MODE_SAT);

    if (MOD_MAX > (2 ** WIDTH) - 1) begin : g_bad_max_hi
        $error("updown_mod_counter: MOD_MAX does not fit in WIDTH bits");
    end
    if (MOD_MAX == 0) begin : g_bad_max_zero
        $error("updown_mod_counter: MOD_MAX must be at least 1");
    end
    if (DEB_CYCLES < 1) begin : g_bad_deb
        $error("updown_mod_counter: DEB_CYCLES must be >= 1");
    end

    logic [WIDTH-1:0] r_count;
    logic             r_tc;
    logic             w_dir;
    logic [WIDTH-1:0] w_load_clamped;
    logic [WIDTH-1:0] w_count_next;
    logic             w_tc_next;

    // The debounced direction is already registered, so a step on the same
    // edge as a direction update naturally uses the old direction.
    sw_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_dir_deb (
        .clk    (clk),
        .rst_n  (rst_n),
        .sw_in  (dir_sw),
        .sw_out (w_dir)
    );

    assign w_load_clamped = (load_val > C_MAX) ? C_MAX : load_val;

    // Next-count mux: load beats enable beats hold; end steps raise tc.
    // Compares use >= / == 0 so no increment ever needs a carry bit.
    always_comb begin
        w_count_next = r_count;
        w_tc_next    = 1'b0;
        if (load) begin
            w_count_next = w_load_clamped;
        end else if (en) begin
            if (w_dir == DIR_UP) begin
                if (r_count >= C_MAX) begin
                    w_tc_next    = 1'b1;
                    w_count_next = C_SAT ? C_MAX : '0;
                end else begin
                    w_count_next = r_count + WIDTH'(1);
                end
            end else begin
                if (r_count == '0) begin
                    w_tc_next    = 1'b1;
                    w_count_next = C_SAT ? '0 : C_MAX;
                end else begin
                    w_count_next = r_count - WIDTH'(1);
                end
            end
        end
    end

    // Count and terminal-count registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_tc    <= 1'b0;
        end else begin
            r_count <= w_count_next;
            r_tc    <= w_tc_next;
        end
    end

    assign count  = r_count;
    assign tc     = r_tc;
    assign dir    = w_dir;
    assign at_max = (r_count == C_MAX);
    assign at_min = (r_count == '0);

endmodule

// File: tb/tb_updown_mod_counter.sv
// Directed bench: four counter configurations share one stimulus stream.
//   d0: MOD_MAX=5 wrap   d1: MOD_MAX=5 saturate
//   d2: MOD_MAX=7 wrap   d3: MOD_MAX=7 saturate   (all WIDTH=3, DEB_CYCLES=4)
module tb_updown_mod_counter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       dir_sw = 1'b0;
    logic       load = 1'b0;
    logic [2:0] load_val = 3'd0;

    logic [2:0] cnt [4];
    logic       dir_o [4];
    logic       tc_o [4];
    logic       amax [4];
    logic       amin [4];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    updown_mod_counter #(.WIDTH(3), .MOD_MAX(5), .SAT_MODE(0), .DEB_CYCLES(4)) d0 (
        .clk(clk), .rst_n(rst_n), .en(en), .dir_sw(dir_sw), .load(load), .load_val(load_val),
        .count(cnt[0]), .dir(dir_o[0]), .tc(tc_o[0]), .at_max(amax[0]), .at_min(amin[0]));
    updown_mod_counter #(.WIDTH(3), .MOD_MAX(5), .SAT_MODE(1), .DEB_CYCLES(4)) d1 (
        .clk(clk), .rst_n(rst_n), .en(en), .dir_sw(dir_sw), .load(load), .load_val(load_val),
        .count(cnt[1]), .dir(dir_o[1]), .tc(tc_o[1]), .at_max(amax[1]), .at_min(amin[1]));
    updown_mod_counter #(.WIDTH(3), .MOD_MAX(7), .SAT_MODE(0), .DEB_CYCLES(4)) d2 (
        .clk(clk), .rst_n(rst_n), .en(en), .dir_sw(dir_sw), .load(load), .load_val(load_val),
        .count(cnt[2]), .dir(dir_o[2]), .tc(tc_o[2]), .at_max(amax[2]), .at_min(amin[2]));
    updown_mod_counter #(.WIDTH(3), .MOD_MAX(7), .SAT_MODE(1), .DEB_CYCLES(4)) d3 (
        .clk(clk), .rst_n(rst_n), .en(en), .dir_sw(dir_sw), .load(load), .load_val(load_val),
        .count(cnt[3]), .dir(dir_o[3]), .tc(tc_o[3]), .at_max(amax[3]), .at_min(amin[3]));

    // Single comparison point for the whole bench
    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Compare count, tc and dir of all four instances against expectations
    task automatic check_all(input string tag,
                             input int c0, input int c1, input int c2, input int c3,
                             input int t0, input int t1, input int t2, input int t3,
                             input int d);
        int ec [4];
        int et [4];
        ec = '{c0, c1, c2, c3};
        et = '{t0, t1, t2, t3};
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s d%0d count", tag, i), int'(cnt[i]), ec[i]);
            check($sformatf("%s d%0d tc", tag, i), int'(tc_o[i]), et[i]);
            check($sformatf("%s d%0d dir", tag, i), int'(dir_o[i]), d);
        end
        $display("t=%0t %s: count=%0d/%0d/%0d/%0d tc=%0d%0d%0d%0d dir=%0d", $time, tag,
                 cnt[0], cnt[1], cnt[2], cnt[3], tc_o[0], tc_o[1], tc_o[2], tc_o[3], dir_o[0]);
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ---------------- reset state ----------------
        repeat (3) step();
        #3;
        rst_n = 1'b1;
        step();
        check_all("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("reset d0 at_min", int'(amin[0]), 1);
        check("reset d0 at_max", int'(amax[0]), 0);

        // ---------------- test 1: async reset mid-count, then count up ----------------
        en = 1'b1;
        dir_sw = 1'b1;              // starts a direction change that reset must abort
        step(); step(); step();
        check_all("t1 pre-reset", 3, 3, 3, 3, 0, 0, 0, 0, 0);
        en = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        check_all("t1 async reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        dir_sw = 1'b0;
        step();
        rst_n = 1'b1;
        en = 1'b1;
        step(); check_all("t1 up1", 1, 1, 1, 1, 0, 0, 0, 0, 0);
        step(); check_all("t1 up2", 2, 2, 2, 2, 0, 0, 0, 0, 0);
        step(); check_all("t1 up3", 3, 3, 3, 3, 0, 0, 0, 0, 0);
        step(); check_all("t1 up4", 4, 4, 4, 4, 0, 0, 0, 0, 0);
        step(); check_all("t1 up5", 5, 5, 5, 5, 0, 0, 0, 0, 0);
        check("t1 d0 at_max", int'(amax[0]), 1);
        step(); check_all("t1 wrap", 0, 5, 6, 6, 1, 1, 0, 0, 0);
        en = 1'b0;
        step(); check_all("t1 hold", 0, 5, 6, 6, 0, 0, 0, 0, 0);

        // ---------------- test 3: debounce glitch rejected ----------------
        dir_sw = 1'b1;
        step(); step(); step();
        dir_sw = 1'b0;
        repeat (7) step();
        check_all("t3 glitch", 0, 5, 6, 6, 0, 0, 0, 0, 0);

        // ---------------- test 3: held switch accepted after 6 cycles ----------------
        dir_sw = 1'b1;
        repeat (5) step();
        check_all("t3 edge+5", 0, 5, 6, 6, 0, 0, 0, 0, 0);
        step();
        check_all("t3 edge+6", 0, 5, 6, 6, 0, 0, 0, 0, 1);

        // ---------------- test 2: wrap/saturate going down from 0 ----------------
        load = 1'b1; load_val = 3'd0;
        step();
        load = 1'b0;
        check_all("t2 load0", 0, 0, 0, 0, 0, 0, 0, 0, 1);
        check("t2 d2 at_min", int'(amin[2]), 1);
        en = 1'b1;
        step();
        en = 1'b0;
        check_all("t2 down wrap", 5, 0, 7, 0, 1, 1, 1, 1, 1);
        check("t2 d0 at_max", int'(amax[0]), 1);
        check("t2 d2 at_max", int'(amax[2]), 1);
        step();
        check_all("t2 tc clears", 5, 0, 7, 0, 0, 0, 0, 0, 1);

        // plain decrement
        load = 1'b1; load_val = 3'd3;
        step();
        load = 1'b0; en = 1'b1;
        step();
        en = 1'b0;
        check_all("down step", 2, 2, 2, 2, 0, 0, 0, 0, 1);

        // ---------------- test 4: load priority and clamp ----------------
        load = 1'b1; en = 1'b1; load_val = 3'd7;
        step();
        check_all("t4 load7", 5, 5, 7, 7, 0, 0, 0, 0, 1);
        load_val = 3'd2;
        step();
        check_all("t4 load2", 2, 2, 2, 2, 0, 0, 0, 0, 1);
        load = 1'b0; en = 1'b0;

        // ---------------- test 5: full-range config at top end ----------------
        dir_sw = 1'b0;
        repeat (6) step();
        check_all("t5 dir up", 2, 2, 2, 2, 0, 0, 0, 0, 0);
        load = 1'b1; load_val = 3'd7;
        step();
        load = 1'b0;
        check_all("t5 load7", 5, 5, 7, 7, 0, 0, 0, 0, 0);
        en = 1'b1;
        step(); check_all("t5 en1", 0, 5, 0, 7, 1, 1, 1, 1, 0);
        step(); check_all("t5 en2", 1, 5, 1, 7, 0, 1, 0, 1, 0);
        step(); check_all("t5 en3", 2, 5, 2, 7, 0, 1, 0, 1, 0);
        en = 1'b0;
        step(); check_all("t5 idle", 2, 5, 2, 7, 0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
